// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // RV32M funct3 encodings
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_e;

  // Divide-class ops (DIV/DIVU/REM/REMU) all have funct3[2] set
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = XLEN'(1) << (XLEN - 1);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;     // {product hi, lo} or {remainder, quotient}
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              zero_q, zero_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg, b_neg, sign_flag;
  logic              is_ovf, is_special;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_borrow;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] mul_next, div_next, fin_val, fin_sgn;
  logic [XLEN-1:0]   fin_res;

  // Operand signedness, magnitudes, sign flag and special-case detection at accept
  always_comb begin
    a_signed   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg      = a_signed & a[XLEN-1];
    b_neg      = b_signed & b[XLEN-1];
    mag_a      = a_neg ? -a : a;
    mag_b      = b_neg ? -b : b;
    // remainder follows the dividend; everything else follows the sign product
    sign_flag  = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
    is_ovf     = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
    is_special = is_div(op) && ((b == '0) || is_ovf);
  end

  // One iteration step for each algorithm, plus sign correction and result select
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next   = {mul_sum, acc_q[XLEN-1:1]};
    div_sh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff   = div_sh - {1'b0, opb_q};
    div_borrow = div_sh < {1'b0, opb_q};
    div_rem    = div_borrow ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
    div_next   = {div_rem, acc_q[XLEN-2:0], ~div_borrow};
    // a single 2*XLEN negator serves product, quotient and remainder
    if (!is_div(op_q))
      fin_val = acc_q;
    else if (op_q[1])
      fin_val = {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]};
    else
      fin_val = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
    fin_sgn = neg_q ? -fin_val : fin_val;
    fin_res = ((op_q == OP_MUL) || is_div(op_q)) ? fin_sgn[XLEN-1:0]
                                                 : fin_sgn[2*XLEN-1:XLEN];
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    zero_d   = zero_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          opb_d  = mag_b;
          cnt_d  = CW'(XLEN - 1);
          busy_d = 1'b1;
          if (is_special) begin
            // final remainder/quotient preloaded raw; FIN applies no correction
            neg_d   = 1'b0;
            acc_d   = (b == '0) ? {a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a};
            state_d = FIN;
          end else begin
            neg_d   = sign_flag;
            acc_d   = {{XLEN{1'b0}}, mag_a};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = is_div(op_q) ? div_next : mul_next;
        if (cnt_q == '0) state_d = FIN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIN: begin
        result_d = fin_res;
        zero_d   = (fin_res == '0);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b1;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expectations, monitor checks on done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        busy, done, zero;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        zero;
    int          due;
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op_i),
    .a      (a_i),
    .b      (b_i),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_zero"}, {31'b0, zero}, {31'b0, e.zero});
        chk({e.name, "_cycle"}, cyc, e.due);
      end
    end
  end

  // Issue an op that the DUT must accept on the next rising edge (call at a negedge)
  task automatic issue(input string name, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] r, input bit fast);
    exp_t e;
    op_i  = o;
    a_i   = x;
    b_i   = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    e.name = name;
    e.res  = r;
    e.zero = (r == 32'h0);
    e.due  = cyc + (fast ? 1 : 33);
    sb.push_back(e);
    chk({name, "_busy"}, {31'b0, busy}, 32'h1);
  endtask

  // Bounded wait for done; returns at the negedge where done is high
  task automatic wait_done(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) return;
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'b0, busy}, 32'h0);
    chk("rst_done",   {31'b0, done}, 32'h0);
    chk("rst_result", result,        32'h0);
    chk("rst_zero",   {31'b0, zero}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL with start pulses while busy; those must be ignored
    issue("mul_neg", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    repeat (4) @(negedge clk);
    op_i = OP_DIVU; a_i = 32'd1234; b_i = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    op_i = OP_MULHU; a_i = 32'h12345678; b_i = 32'h9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_neg");

    // Back-to-back from here on: each issue drives start during the done cycle
    issue("mulh_min",  OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0); wait_done("mulh_min");
    issue("mulhu_max", OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0); wait_done("mulhu_max");
    issue("mulhsu",    OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0); wait_done("mulhsu");
    issue("mulh_m1",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0); wait_done("mulh_m1");
    issue("mul_zero",  OP_MUL,    32'h00000000, 32'd5,        32'h00000000, 1'b0); wait_done("mul_zero");
    issue("div_neg",   OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0); wait_done("div_neg");
    issue("rem_neg",   OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0); wait_done("rem_neg");
    issue("divu",      OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0); wait_done("divu");
    issue("remu",      OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0); wait_done("remu");
    issue("div_negb",  OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0); wait_done("div_negb");
    issue("rem_negb",  OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        1'b0); wait_done("rem_negb");
    issue("divu_z",    OP_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1'b1); wait_done("divu_z");
    issue("remu_z",    OP_REMU,   32'd100,      32'd0,        32'd100,      1'b1); wait_done("remu_z");
    issue("div_ovf",   OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1); wait_done("div_ovf");
    issue("rem_ovf",   OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1); wait_done("rem_ovf");
    issue("div_z_neg", OP_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1); wait_done("div_z_neg");
    issue("rem_z_neg", OP_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1); wait_done("rem_z_neg");
    repeat (3) @(negedge clk);

    // Reset in the middle of a DIV aborts it
    issue("div_abort", OP_DIV, 32'd1000, 32'd3, 32'd333, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy",   {31'b0, busy}, 32'h0);
    chk("abort_done",   {31'b0, done}, 32'h0);
    chk("abort_result", result,        32'h0);
    chk("abort_zero",   {31'b0, zero}, 32'h1);
    sb.delete();
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue("mul_after", OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0);
    wait_done("mul_after");
    repeat (3) @(negedge clk);

    chk("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
